// File: rtl/vexbus_pkg.sv
// vexbus_pkg: owner encoding and address-region constants shared by the vexbus arbiter and decoders.
package vexbus_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IBUS = 2'd1,
    OWN_DBUS = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;
  localparam logic [1:0] REGION_RAM  = 2'b00;
  localparam logic [1:0] REGION_MMIO = 2'b01;
  localparam logic [1:0] REGION_ROM  = 2'b10;
endpackage

// File: rtl/vexbus_decode.sv
// vexbus_decode: flags addresses outside the decoded window or in the unpopulated top region.
module vexbus_decode #(
  parameter int ADR_MAP_BITS = 18
) (
  input  logic [31:0] i_adr,
  output logic        o_unmapped
);
  import vexbus_pkg::*;
  logic [1:0] w_region;
  assign w_region   = i_adr[ADR_MAP_BITS-1 -: 2];
  assign o_unmapped = |(i_adr >> ADR_MAP_BITS) ||
                      !(w_region inside {REGION_RAM, REGION_MMIO, REGION_ROM});
endmodule

// File: rtl/vexbus_arbiter.sv
// vexbus_arbiter: one-grant-per-cycle iBus/dBus/debug arbiter with a one-cycle response pipeline
// and iBus anti-starvation.
module vexbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADR_MAP_BITS = 18
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_run,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_pc,
  output logic        i_cmd_ready,
  output logic        i_rsp_valid,
  output logic        i_rsp_error,
  input  logic        d_cmd_valid,
  input  logic        d_cmd_wr,
  input  logic [3:0]  d_cmd_mask,
  input  logic [31:0] d_cmd_adr,
  input  logic [31:0] d_cmd_data,
  output logic        d_cmd_ready,
  output logic        d_rsp_valid,
  output logic        d_rsp_error,
  input  logic        dbg_mem_op,
  input  logic        dbg_rw,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_do,
  output logic        dbg_mem_rdy,
  output logic [31:0] dbg_di,
  output logic        bus_op,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_di,
  output logic [3:0]  bus_wren,
  input  logic [31:0] bus_do
);
  import vexbus_pkg::*;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  owner_t        w_own, r_own;
  logic          w_i_el, w_d_el, w_g_el, w_wr, w_unm;
  logic          r_wr, r_unm, r_dbg_served;
  logic [SW-1:0] r_starve;
  logic [31:0]   w_adr, r_dbg_di;
  // Grants are gated by reset so every output reads 0 while n_reset is low.
  assign w_g_el = n_reset & dbg_mem_op & ~r_dbg_served;
  assign w_d_el = n_reset & cpu_run & d_cmd_valid;
  assign w_i_el = n_reset & cpu_run & i_cmd_valid;
  assign w_own  = (w_i_el && r_starve == LIM) ? OWN_IBUS :
                  w_g_el ? OWN_DBG : w_d_el ? OWN_DBUS : w_i_el ? OWN_IBUS : OWN_NONE;
  assign w_adr  = w_own == OWN_IBUS ? i_cmd_pc :
                  w_own == OWN_DBUS ? d_cmd_adr :
                  w_own == OWN_DBG  ? dbg_adr : '0;
  assign w_wr   = (w_own == OWN_DBUS && d_cmd_wr) || (w_own == OWN_DBG && !dbg_rw);
  vexbus_decode #(.ADR_MAP_BITS(ADR_MAP_BITS)) u_decode (
    .i_adr      (w_adr),
    .o_unmapped (w_unm)
  );
  assign bus_op      = w_own != OWN_NONE;
  assign bus_adr     = w_adr;
  assign bus_di      = w_own == OWN_DBUS ? d_cmd_data : w_own == OWN_DBG ? dbg_do : '0;
  assign bus_wren    = (w_wr && !w_unm) ? (w_own == OWN_DBUS ? d_cmd_mask : 4'hF) : 4'h0;
  assign i_cmd_ready = w_own == OWN_IBUS;
  assign d_cmd_ready = w_own == OWN_DBUS;
  assign i_rsp_valid = r_own == OWN_IBUS;
  assign i_rsp_error = i_rsp_valid & r_unm;
  assign d_rsp_valid = r_own == OWN_DBUS && !r_wr;
  assign d_rsp_error = d_rsp_valid & r_unm;
  assign dbg_mem_rdy = r_own == OWN_DBG;
  assign dbg_di      = r_dbg_di;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_own        <= OWN_NONE;
      r_wr         <= 1'b0;
      r_unm        <= 1'b0;
      r_dbg_served <= 1'b0;
      r_starve     <= '0;
      r_dbg_di     <= '0;
    end else begin
      r_own        <= w_own;
      r_wr         <= w_wr;
      r_unm        <= w_unm;
      r_dbg_served <= dbg_mem_op & (r_dbg_served | (w_own == OWN_DBG));
      // Any non-iBus grant while a fetch waits counts toward forcing the fetch through.
      r_starve     <= (!i_cmd_valid || !cpu_run || w_own == OWN_IBUS) ? '0 :
                      (w_own != OWN_NONE && r_starve != LIM) ? r_starve + 1'b1 : r_starve;
      if (r_own == OWN_DBG && !r_wr) r_dbg_di <= bus_do;
    end
  end
endmodule

// File: doc/vexbus_arbiter.md
Name: vexbus_arbiter

Overview:
Pipelined three-way arbiter that sits directly downstream of the VexRiscv iBus/dBus and the dbgu32 debug memory port, and upstream of the shared memory/MMIO bus (RAM, ROM, PWM, UART, timer).
It replaces the ad-hoc combinational muxing and fixed-delay acks with a proper cmd/rsp handshake, one grant per cycle, and a one-cycle response pipeline that matches the synchronous-read memories.
It also flags accesses to unmapped addresses and prevents debugger or dBus traffic from starving instruction fetch.

Parameters:
STARVE_LIMIT, 4, consecutive non-iBus grants allowed while iBus is pending before iBus is forced through.
ADR_MAP_BITS, 18, number of low address bits decoded; any set bit above this is unmapped.

Ports:
clk  in  1  system clock.
n_reset  in  1  asynchronous, active-low reset.
cpu_run  in  1  CPU requests are eligible only when high.
i_cmd_valid  in  1  iBus fetch request.
i_cmd_pc  in  32  fetch address.
i_cmd_ready  out  1  fetch accepted this cycle.
i_rsp_valid  out  1  fetch data valid on bus_do.
i_rsp_error  out  1  fetch hit an unmapped address.
d_cmd_valid  in  1  dBus request.
d_cmd_wr  in  1  1 = write.
d_cmd_mask  in  4  byte-write mask.
d_cmd_adr  in  32  data address.
d_cmd_data  in  32  write data.
d_cmd_ready  out  1  dBus command accepted.
d_rsp_valid  out  1  read data valid on bus_do.
d_rsp_error  out  1  read targeted an unmapped address.
dbg_mem_op  in  1  debugger request, level, held until dbg_mem_rdy.
dbg_rw  in  1  1 = read, 0 = write (all four bytes).
dbg_adr  in  32  debugger address.
dbg_do  in  32  debugger write data.
dbg_mem_rdy  out  1  debugger op complete.
dbg_di  out  32  registered read data for the debugger.
bus_op  out  1  bus cycle active (chip-select qualifier).
bus_adr  out  32  bus address.
bus_di  out  32  bus write data.
bus_wren  out  4  byte write enables.
bus_do  in  32  OR-combined slave read data, valid one cycle after bus_op.

Behaviour:
- Reset (asynchronous, n_reset low): all outputs 0; owner pipeline register = NONE; starve counter = 0; dbg_served = 0.
- Grant stage (combinational, every cycle):
  - Priority: DBG > DBUS > IBUS.
  - DBG is eligible only when dbg_mem_op=1 and dbg_served=0.
  - DBUS and IBUS are eligible only when cpu_run=1.
  - Override: when starve_cnt == STARVE_LIMIT and i_cmd_valid is eligible, IBUS wins regardless of the others.
- Winner effects:
  - Drives bus_op=1 and its own address and data onto the bus.
  - bus_wren: DBUS uses d_cmd_mask when wr, else 0; DBG uses 4'hF when dbg_rw=0, else 0; IBUS uses 0.
  - Asserts its own cmd_ready for this cycle only.
- No winner: bus_op=0, bus_adr/bus_di/bus_wren = 0.
- Response stage (registered): the owner, wr flag and unmapped flag are registered at the grant edge, and the response fires in the next cycle:
  - IBUS: i_rsp_valid=1; i_rsp_error = unmapped.
  - DBUS read: d_rsp_valid=1; d_rsp_error = unmapped. DBUS write: no rsp.
  - DBG: dbg_mem_rdy=1. For reads, dbg_di is loaded from bus_do on that edge and holds until the next DBG read.
- Latency and throughput:
  - Grant to response is exactly 1 cycle.
  - Back-to-back grants are allowed every cycle, so throughput is 1 op/cycle.
- Unmapped decode: any of adr[31:ADR_MAP_BITS] set, or adr[17:16]==2'b11. The bus cycle still issues with bus_wren forced to 0, so the access is harmless.
- dbg_served:
  - Set on a DBG grant; cleared when dbg_mem_op=0.
  - Guarantees exactly one bus op per debugger assertion.
- starve_cnt:
  - Cleared on an IBUS grant, or whenever i_cmd_valid=0 or cpu_run=0.
  - Incremented (saturating at STARVE_LIMIT) on each DBG/DBUS grant while i_cmd_valid=1.
- cpu_run falling while a CPU response is pending: the response is still delivered next cycle.
- Simultaneous DBG+DBUS+IBUS: DBG, then DBUS, then IBUS over three consecutive cycles, with STARVE_LIMIT not reached.
- Requesters hold cmd signals stable until cmd_ready. The arbiter never asserts cmd_ready to a non-requesting port.

Decomposition:
- Shared package (vexbus_pkg): owner encoding (NONE/IBUS/DBUS/DBG, 2 bits), region constants (RAM 2'b00, MMIO 2'b01, ROM 2'b10).
- Sub-module: vexbus_decode, a combinational address to unmapped-flag decoder, reusable by the top-level chip-select logic.

Test Plan:
- iBus only, pc=0x20000, bus_do=0x00072783 → i_cmd_ready in cycle 0; i_rsp_valid=1, error=0 in cycle 1; bus_wren=0.
- dBus write adr=0x10000, mask=4'b0001, data=0xFF, simultaneous with iBus → cycle 0: bus_wren=0001, d_cmd_ready; cycle 1: iBus granted; no d_rsp_valid.
- dbg_mem_op held 5 cycles, read adr=0x4 with bus_do=0xDEADBEEF → exactly one bus_op; dbg_mem_rdy one cycle later; dbg_di=0xDEADBEEF held; no second grant until dbg_mem_op drops.
- dBus continuously valid + iBus valid, STARVE_LIMIT=4 → 4 dBus grants, then 1 iBus grant, repeating.
- Read adr=0x30000 on dBus → bus_wren=0, d_rsp_error=1 next cycle. Write to 0x30000 → bus_wren=0.
- Assert n_reset=0 the cycle after an iBus grant → i_rsp_valid stays 0, all outputs 0 immediately; after release, the first request is handled normally.
